// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock-enable divider.
// Holds the handshake FSM state encoding and the default divide width and
// reset divide value used by clk_div_ctrl, clk_en_counter and the interface.
package clk_div_pkg;

    localparam int DIV_W_DEF     = 8;
    localparam int RESET_DIV_DEF = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage : clk_div_pkg

// File: rtl/clk_div_ctrl_if.sv
// Configuration and status bundle for clk_div_ctrl.
// master (requester): drives cfg_req/cfg_div and observes cfg_ack, busy,
//                     cur_div and clk_en.
// slave  (divider)  : the reverse directions.
interface clk_div_ctrl_if
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);
    logic             cfg_req;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             busy;
    logic [DIV_W-1:0] cur_div;
    logic             clk_en;

    modport master (
        output cfg_req, cfg_div,
        input  cfg_ack, busy, cur_div, clk_en
    );

    modport slave (
        input  cfg_req, cfg_div,
        output cfg_ack, busy, cur_div, clk_en
    );
endinterface : clk_div_ctrl_if

// File: rtl/clk_en_counter.sv
// Period counter for the clock-enable divider.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   load      : replace the divide field and restart the period (asserted
//               only on a terminal cycle, so periods are never cut short)
//   load_div  : divide field to load
//   cur_div   : divide field currently in effect
//   terminal  : high in the last cycle of a period (cnt == cur_div)
module clk_en_counter
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic [DIV_W-1:0] cur_div,
    output logic             terminal
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cur_div_r;

    // Period counter and active divide field.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {DIV_W{1'b0}};
            cur_div_r <= DIV_W'(RESET_DIV);
        end else if (load) begin
            cnt_r     <= {DIV_W{1'b0}};
            cur_div_r <= load_div;
        end else if (cnt_r == cur_div_r) begin
            cnt_r     <= {DIV_W{1'b0}};
        end else begin
            cnt_r     <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Terminal decode uses registers only, so clk_en has no input path.
    always_comb begin
        terminal = (cnt_r == cur_div_r);
        cur_div  = cur_div_r;
    end

endmodule : clk_en_counter

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock-enable divider controller.
// Emits a one-cycle clk_en strobe every (cur_div+1) cycles. A new divide
// field is requested with a 4-phase cfg_req/cfg_ack handshake and applied
// only at a period boundary.
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   cpu_idle : (only with CLK_DIV_CTRL_IDLE_GATE_EN) suppress clk_en for
//              whole periods while the CPU is idle
//   bus      : clk_div_ctrl_if.slave (cfg_req, cfg_div, cfg_ack, busy,
//              cur_div, clk_en)
// Optional feature macro: CLK_DIV_CTRL_IDLE_GATE_EN
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst,
`ifdef CLK_DIV_CTRL_IDLE_GATE_EN
    input  logic           cpu_idle,
`endif
    clk_div_ctrl_if.slave  bus
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [DIV_W-1:0] pend_div_r;
    logic             terminal_s;
    logic             load_s;
    logic             busy_s;
    logic             ack_s;
    logic [DIV_W-1:0] cur_div_s;

    clk_en_counter #(
        .DIV_W     (DIV_W),
        .RESET_DIV (RESET_DIV)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_div (pend_div_r),
        .cur_div  (cur_div_s),
        .terminal (terminal_s)
    );

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the requested divide once; later cfg_div changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_div_r <= {DIV_W{1'b0}};
        end else if ((state_r == IDLE) && bus.cfg_req) begin
            pend_div_r <= bus.cfg_div;
        end else begin
            pend_div_r <= pend_div_r;
        end
    end

    // Next-state logic. A request dropped during WAIT is still completed.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.cfg_req) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (terminal_s) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            ACK: begin
                if (!bus.cfg_req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        load_s = 1'b0;
        busy_s = 1'b0;
        ack_s  = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            WAIT: begin
                busy_s = 1'b1;
                load_s = terminal_s;
            end
            ACK: begin
                busy_s = 1'b1;
                ack_s  = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

`ifdef CLK_DIV_CTRL_IDLE_GATE_EN
    logic gate_r;

    // Gate flag changes only on terminal cycles, so gating is whole-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_r <= 1'b0;
        end else if (terminal_s) begin
            gate_r <= cpu_idle;
        end else begin
            gate_r <= gate_r;
        end
    end

    assign bus.clk_en = terminal_s & ~gate_r;
`else
    assign bus.clk_en = terminal_s;
`endif

    assign bus.cfg_ack = ack_s;
    assign bus.busy    = busy_s;
    assign bus.cur_div = cur_div_s;

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl. Each scenario task queues the
// per-cycle expected outputs for its stimulus plan, then steps the clock,
// popping and comparing one expectation per cycle.
module tb_clk_div_ctrl;
    import clk_div_pkg::*;

    typedef struct packed {
        logic       en;
        logic [7:0] cur;
        logic       busy;
        logic       ack;
    } exp_t;

    logic clk;
    logic rst;
`ifdef CLK_DIV_CTRL_IDLE_GATE_EN
    logic cpu_idle;
`endif

    exp_t sb_q[$];
    int   tests_run;
    int   tests_failed;

    clk_div_ctrl_if #(.DIV_W(8)) bus ();

    clk_div_ctrl #(
        .DIV_W     (8),
        .RESET_DIV (7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef CLK_DIV_CTRL_IDLE_GATE_EN
        .cpu_idle (cpu_idle),
`endif
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // After return the bench is in cycle 0 following reset release.
    task automatic do_reset;
        rst         = 1'b1;
        bus.cfg_req = 1'b0;
        bus.cfg_div = 8'd0;
        tick();
        rst = 1'b0;
    endtask

    function automatic exp_t mk(input logic en, input logic [7:0] cur,
                                input logic busy, input logic ack);
        exp_t e;
        e.en = en; e.cur = cur; e.busy = busy; e.ack = ack;
        return e;
    endfunction

    task automatic test_reset;
        exp_t o, e;
        do_reset();
        for (int c = 0; c < 24; c++) sb_q.push_back(mk(c % 8 == 7, 8'd7, 1'b0, 1'b0));
        for (int c = 0; c < 24; c++) begin
            o = {bus.clk_en, bus.cur_div, bus.busy, bus.cfg_ack};
            e = sb_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset c=%0d got en=%b cur=%0d busy=%b ack=%b exp en=%b cur=%0d busy=%b ack=%b",
                         c, o.en, o.cur, o.busy, o.ack, e.en, e.cur, e.busy, e.ack);
            end
            tick();
        end
    endtask

    // Request div=3 at cnt=2; cfg_div is disturbed during WAIT.
    task automatic test_load;
        exp_t o, e;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c <= 2)      sb_q.push_back(mk(1'b0, 8'd7, 1'b0, 1'b0));
            else if (c <= 7) sb_q.push_back(mk(c == 7, 8'd7, 1'b1, 1'b0));
            else if (c == 8) sb_q.push_back(mk(1'b0, 8'd3, 1'b1, 1'b1));
            else             sb_q.push_back(mk((c - 8) % 4 == 3, 8'd3, 1'b0, 1'b0));
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin bus.cfg_req = 1'b1; bus.cfg_div = 8'd3; end
            if (c == 4) bus.cfg_div = 8'd5;
            if (c == 8) bus.cfg_req = 1'b0;
            o = {bus.clk_en, bus.cur_div, bus.busy, bus.cfg_ack};
            e = sb_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL load c=%0d got en=%b cur=%0d busy=%b ack=%b exp en=%b cur=%0d busy=%b ack=%b",
                         c, o.en, o.cur, o.busy, o.ack, e.en, e.cur, e.busy, e.ack);
            end
            tick();
        end
    endtask

    // Request on a terminal cycle: load waits a whole further period.
    task automatic test_terminal_capture;
        exp_t o, e;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            if (c <= 7)       sb_q.push_back(mk(c == 7, 8'd7, 1'b0, 1'b0));
            else if (c <= 15) sb_q.push_back(mk(c == 15, 8'd7, 1'b1, 1'b0));
            else if (c == 16) sb_q.push_back(mk(1'b0, 8'd1, 1'b1, 1'b1));
            else              sb_q.push_back(mk((c - 16) % 2 == 1, 8'd1, 1'b0, 1'b0));
        end
        for (int c = 0; c < 24; c++) begin
            if (c == 7)  begin bus.cfg_req = 1'b1; bus.cfg_div = 8'd1; end
            if (c == 16) bus.cfg_req = 1'b0;
            o = {bus.clk_en, bus.cur_div, bus.busy, bus.cfg_ack};
            e = sb_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL term_capture c=%0d got en=%b cur=%0d busy=%b ack=%b exp en=%b cur=%0d busy=%b ack=%b",
                         c, o.en, o.cur, o.busy, o.ack, e.en, e.cur, e.busy, e.ack);
            end
            tick();
        end
    endtask

    // div=0 (request dropped early, still completes), then back to div=7.
    task automatic test_div_zero;
        exp_t o, e;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            if (c == 0)       sb_q.push_back(mk(1'b0, 8'd7, 1'b0, 1'b0));
            else if (c <= 7)  sb_q.push_back(mk(c == 7, 8'd7, 1'b1, 1'b0));
            else if (c == 8)  sb_q.push_back(mk(1'b1, 8'd0, 1'b1, 1'b1));
            else if (c <= 10) sb_q.push_back(mk(1'b1, 8'd0, 1'b0, 1'b0));
            else if (c == 11) sb_q.push_back(mk(1'b1, 8'd0, 1'b1, 1'b0));
            else if (c == 12) sb_q.push_back(mk(1'b0, 8'd7, 1'b1, 1'b1));
            else              sb_q.push_back(mk((c - 12) % 8 == 7, 8'd7, 1'b0, 1'b0));
        end
        for (int c = 0; c < 22; c++) begin
            if (c == 0)  begin bus.cfg_req = 1'b1; bus.cfg_div = 8'd0; end
            if (c == 3)  bus.cfg_req = 1'b0;
            if (c == 10) begin bus.cfg_req = 1'b1; bus.cfg_div = 8'd7; end
            if (c == 12) bus.cfg_req = 1'b0;
            o = {bus.clk_en, bus.cur_div, bus.busy, bus.cfg_ack};
            e = sb_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL div_zero c=%0d got en=%b cur=%0d busy=%b ack=%b exp en=%b cur=%0d busy=%b ack=%b",
                         c, o.en, o.cur, o.busy, o.ack, e.en, e.cur, e.busy, e.ack);
            end
            tick();
        end
    endtask

    // Reset while in WAIT: pending divide is discarded.
    task automatic test_reset_in_wait;
        exp_t o, e;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            if (c <= 3)      sb_q.push_back(mk(1'b0, 8'd7, 1'b0, 1'b0));
            else if (c <= 5) sb_q.push_back(mk(1'b0, 8'd7, 1'b1, 1'b0));
            else             sb_q.push_back(mk((c - 6) % 8 == 7, 8'd7, 1'b0, 1'b0));
        end
        for (int c = 0; c < 24; c++) begin
            if (c == 3) begin bus.cfg_req = 1'b1; bus.cfg_div = 8'd2; end
            if (c == 5) begin rst = 1'b1; bus.cfg_req = 1'b0; end
            if (c == 6) rst = 1'b0;
            o = {bus.clk_en, bus.cur_div, bus.busy, bus.cfg_ack};
            e = sb_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_wait c=%0d got en=%b cur=%0d busy=%b ack=%b exp en=%b cur=%0d busy=%b ack=%b",
                         c, o.en, o.cur, o.busy, o.ack, e.en, e.cur, e.busy, e.ack);
            end
            tick();
        end
    endtask

    // Requesting the ratio already in effect keeps period timing unchanged.
    task automatic test_same_ratio;
        exp_t o, e;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c <= 1)      sb_q.push_back(mk(1'b0, 8'd7, 1'b0, 1'b0));
            else if (c <= 7) sb_q.push_back(mk(c == 7, 8'd7, 1'b1, 1'b0));
            else if (c == 8) sb_q.push_back(mk(1'b0, 8'd7, 1'b1, 1'b1));
            else             sb_q.push_back(mk(c % 8 == 7, 8'd7, 1'b0, 1'b0));
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin bus.cfg_req = 1'b1; bus.cfg_div = 8'd7; end
            if (c == 8) bus.cfg_req = 1'b0;
            o = {bus.clk_en, bus.cur_div, bus.busy, bus.cfg_ack};
            e = sb_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL same_ratio c=%0d got en=%b cur=%0d busy=%b ack=%b exp en=%b cur=%0d busy=%b ack=%b",
                         c, o.en, o.cur, o.busy, o.ack, e.en, e.cur, e.busy, e.ack);
            end
            tick();
        end
    endtask

`ifdef CLK_DIV_CTRL_IDLE_GATE_EN
    // div=3; idle from cnt=1 (c=13) to cnt=1 (c=25): strobes 19,23,27 gated.
    task automatic test_idle_gate;
        exp_t o, e;
        logic term;
        cpu_idle = 1'b0;
        do_reset();
        for (int c = 0; c < 36; c++) begin
            if (c == 0)      sb_q.push_back(mk(1'b0, 8'd7, 1'b0, 1'b0));
            else if (c <= 7) sb_q.push_back(mk(c == 7, 8'd7, 1'b1, 1'b0));
            else if (c == 8) sb_q.push_back(mk(1'b0, 8'd3, 1'b1, 1'b1));
            else begin
                term = ((c - 8) % 4 == 3);
                sb_q.push_back(mk(term && !(c >= 16 && c <= 27), 8'd3, 1'b0, 1'b0));
            end
        end
        for (int c = 0; c < 36; c++) begin
            if (c == 0)  begin bus.cfg_req = 1'b1; bus.cfg_div = 8'd3; end
            if (c == 8)  bus.cfg_req = 1'b0;
            if (c == 13) cpu_idle = 1'b1;
            if (c == 25) cpu_idle = 1'b0;
            o = {bus.clk_en, bus.cur_div, bus.busy, bus.cfg_ack};
            e = sb_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL idle_gate c=%0d got en=%b cur=%0d busy=%b ack=%b exp en=%b cur=%0d busy=%b ack=%b",
                         c, o.en, o.cur, o.busy, o.ack, e.en, e.cur, e.busy, e.ack);
            end
            tick();
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.cfg_req  = 1'b0;
        bus.cfg_div  = 8'd0;
`ifdef CLK_DIV_CTRL_IDLE_GATE_EN
        cpu_idle     = 1'b0;
`endif
        test_reset();
        test_load();
        test_terminal_capture();
        test_div_zero();
        test_reset_in_wait();
        test_same_ratio();
`ifdef CLK_DIV_CTRL_IDLE_GATE_EN
        test_idle_gate();
`endif
        tests_run++;
        if (sb_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_clk_div_ctrl

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime-programmable clock-enable divider controller for the processor clock domain.
- Replaces a fixed ripple divide-by-8 with a single-clock counter that emits a `clk_en` strobe once per programmable period.
- The processor/config logic requests a new divide ratio over a 4-phase req/ack handshake.
- The new ratio is applied only at a period boundary, so no short or long enable period is ever produced.

Parameters:
- DIV_W, 8, width of divide field; ratio = div+1, range 1..2^DIV_W.
- RESET_DIV, 7, divide field loaded at reset (divide-by-8).

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_req  in  1  request to load cfg_div; held high until cfg_ack seen.
- cfg_div  in  DIV_W  requested divide field; stable while cfg_req high.
- cfg_ack  out  1  high from the cycle the new ratio is live until cfg_req falls.
- busy  out  1  high while a request is pending (states WAIT, ACK).
- cur_div  out  DIV_W  divide field currently in effect.
- clk_en  out  1  one-cycle enable strobe per period.

Behaviour:
- Reset (rst high at posedge):
  - cnt=0, cur_div=RESET_DIV, pend_div=0, state=IDLE, cfg_ack=0.
  - Resulting outputs: busy=0, clk_en=(RESET_DIV==0).
  - Reset mid-operation aborts any pending request; requester must re-issue.
- Counter: cnt increments each cycle; at terminal cycle (cnt==cur_div) it wraps to 0.
- clk_en = (cnt==cur_div), decoded only from registers; no input-to-output combinational path.
  - RESET_DIV=7: clk_en is high in the 8th cycle after reset release, then every 8 cycles.
  - div=0: clk_en is constantly high.
- FSM states IDLE, WAIT, ACK:
  - IDLE: if cfg_req, latch pend_div<=cfg_div and go to WAIT. The boundary is not checked in the capture cycle, even if that cycle is terminal.
  - WAIT: on a terminal cycle, load cur_div<=pend_div and cnt<=0, then go to ACK. The old period completes normally, so its terminal clk_en still fires.
  - ACK: cfg_ack=1; stay until cfg_req==0, then go to IDLE.
- Apply latency from the capture cycle:
  - minimum 2 cycles (capture cycle, then a terminal cycle);
  - maximum old ratio+1 cycles.
- Request with cfg_div==cur_div: full handshake still runs; period timing is unchanged.
- cfg_req dropped before ack is a protocol violation; the FSM ignores it and completes the load.
- cfg_div changes while in WAIT/ACK have no effect (pend_div is already latched).

Optional Feature:
- Macro CLK_DIV_CTRL_IDLE_GATE_EN.
- Defined:
  - Adds input port `cpu_idle` (1 bit).
  - A gate flag samples cpu_idle only on terminal cycles.
  - While the flag is set, clk_en is forced 0; cnt, the FSM and the handshake keep running.
  - Gating and ungating take effect only on whole-period boundaries.
- Undefined: no cpu_idle port; clk_en is never gated.

Decomposition:
- Shared package clk_div_pkg:
  - state enum {IDLE, WAIT, ACK};
  - DIV_W default;
  - RESET_DIV default.
- One natural sub-module, clk_en_counter:
  - contains cnt, cur_div, the load port, and terminal decode;
  - exports the terminal flag to the FSM in clk_div_ctrl.

Test Plan:
- Reset release with defaults -> clk_en pulses at cycles 7, 15, 23; cur_div=7; busy=0; cfg_ack=0.
- In IDLE at cnt=2, cfg_req with cfg_div=3 ->
  - busy rises next cycle;
  - clk_en fires at cnt=7;
  - cur_div=3 and cfg_ack=1 in the following cycle;
  - subsequent clk_en every 4 cycles.
- cfg_req asserted exactly on a terminal cycle (cnt==7), cfg_div=1 -> no load on that boundary; load at the next terminal cycle 8 cycles later (latency 9); then clk_en every 2 cycles.
- cfg_div=0 request -> after ack, clk_en is continuously high; a later cfg_div=7 request loads on the very next cycle (every cycle is terminal).
- rst asserted while in WAIT -> state=IDLE, cur_div=7, cnt=0, cfg_ack stays 0; the old pend_div is never applied.
- With CLK_DIV_CTRL_IDLE_GATE_EN, div=3:
  - cpu_idle rises at cnt=1 -> the clk_en at cnt=3 still fires; later strobes are suppressed;
  - cpu_idle falls mid-period -> strobes resume from the next boundary onward, not before.
